// File: rtl/uart_feeder_pkg.sv
// Shared types and default constants for the UART transmit feeder.
package uart_feeder_pkg;

    localparam int FEEDER_DEPTH   = 8;
    localparam int FEEDER_TIMEOUT = 4;
    localparam int FEEDER_COUNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } feeder_state_t;

    // Bits needed to hold a countdown value 0..t (at least one bit).
    function automatic int timer_width(input int t);
        return (t < 2) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Byte FIFO with wrapping pointers and a separate occupancy counter.
// The head byte is read combinationally so the consumer can capture it
// on the same edge that it pops.
module sync_fifo
    import uart_feeder_pkg::*;
#(
    parameter int DEPTH = FEEDER_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_flush,
    input  logic                      i_push_valid,
    input  logic [7:0]                i_push_data,
    output logic                      o_push_ready,
    input  logic                      i_pop,
    output logic [7:0]                o_head,
    output logic [FEEDER_COUNT_W-1:0] o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [FEEDER_COUNT_W-1:0] FULL_COUNT = FEEDER_COUNT_W'(DEPTH);

    logic [7:0]                r_mem [DEPTH];
    logic [PW-1:0]             r_wr_ptr;
    logic [PW-1:0]             r_rd_ptr;
    logic [FEEDER_COUNT_W-1:0] r_count;
    logic                      w_push;
    logic                      w_pop;

    // Ready comes only from registered occupancy plus the flush/reset gates,
    // so a push can never land on a full FIFO.
    assign o_push_ready = !rst && !i_flush && (r_count < FULL_COUNT);
    assign w_push       = i_push_valid && o_push_ready;
    assign w_pop        = i_pop && !i_flush && (r_count != '0);
    assign o_head       = r_mem[r_rd_ptr];
    assign o_count      = r_count;

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the queue outright.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + FEEDER_COUNT_W'(1);
                2'b01:   r_count <= r_count - FEEDER_COUNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Queues upstream bytes and hands them one at a time to a UART transmitter,
// watching for the transmitter's busy handshake and flagging a missing one.
module uart_tx_feeder
    import uart_feeder_pkg::*;
#(
    parameter int DEPTH   = FEEDER_DEPTH,
    parameter int TIMEOUT = FEEDER_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_s_valid,
    input  logic [7:0]                i_s_data,
    output logic                      o_s_ready,
    input  logic                      i_flush,
    output logic                      o_tx_start,
    output logic [7:0]                o_tx_data,
    input  logic                      i_tx_busy,
    output logic [FEEDER_COUNT_W-1:0] o_fifo_count,
    output logic                      o_timeout_err,
    input  logic                      i_clear_err
);

    localparam int TW = timer_width(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT);

    feeder_state_t             r_state;
    logic                      r_tx_start;
    logic [7:0]                r_tx_data;
    logic [TW-1:0]             r_timer;
    logic                      r_timeout_err;
    logic                      w_pop;
    logic [7:0]                w_head;
    logic [FEEDER_COUNT_W-1:0] w_count;

    // Pop only from IDLE; a flush in the same cycle wins over the pop.
    assign w_pop = (r_state == ST_IDLE) && (w_count != '0) && !i_flush;

    sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (i_flush),
        .i_push_valid (i_s_valid),
        .i_push_data  (i_s_data),
        .o_push_ready (o_s_ready),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_count      (w_count)
    );

    assign o_tx_start    = r_tx_start;
    assign o_tx_data     = r_tx_data;
    assign o_fifo_count  = w_count;
    assign o_timeout_err = r_timeout_err;

    // Handshake FSM with registered outputs; a timeout set overrides a clear
    // in the same cycle because its assignment comes later in the block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_tx_start    <= 1'b0;
            r_tx_data     <= 8'h00;
            r_timer       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (i_clear_err) begin
                r_timeout_err <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_tx_data  <= w_head;
                        r_tx_start <= 1'b1;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    r_tx_start <= 1'b0;
                    r_timer    <= TIMER_LOAD;
                    r_state    <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (i_tx_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_timer <= TW'(1)) begin
                        r_timer       <= '0;
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_tx_start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: a cycle table for latency, timeout,
// error clear and flush-vs-pop, then sequences with a transmitter model.
module tb_uart_tx_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       flush = 1'b0;
    logic       clear_err = 1'b0;
    logic       tbl_busy = 1'b0;
    logic       model_en = 1'b0;
    logic       tx_busy;
    logic       s_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [4:0] fifo_count;
    logic       timeout_err;

    logic       m_busy, m_d1, m_d2;
    int         m_cnt;
    int         busy_len = 4;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] starts_q[$];
    logic       busy_q[$];
    logic [7:0] exp_q[$];

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       f;
        logic       b;
        logic       c;
        logic       e_rdy;
        logic       e_st;
        logic [7:0] e_txd;
        logic [4:0] e_cnt;
        logic       e_err;
    } vec_t;

    vec_t tbl[25];

    always #5 clk = ~clk;

    assign tx_busy = model_en ? m_busy : tbl_busy;

    uart_tx_feeder #(.DEPTH(8), .TIMEOUT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_s_valid     (s_valid),
        .i_s_data      (s_data),
        .o_s_ready     (s_ready),
        .i_flush       (flush),
        .o_tx_start    (tx_start),
        .o_tx_data     (tx_data),
        .i_tx_busy     (tx_busy),
        .o_fifo_count  (fifo_count),
        .o_timeout_err (timeout_err),
        .i_clear_err   (clear_err)
    );

    // Transmitter model: busy rises two edges after it sees tx_start, stays high busy_len cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_d1   <= 1'b0;
            m_d2   <= 1'b0;
            m_cnt  <= 0;
        end else begin
            m_d1 <= tx_start;
            m_d2 <= m_d1;
            if (m_d2) begin
                m_busy <= 1'b1;
                m_cnt  <= busy_len - 1;
            end else if (m_busy) begin
                if (m_cnt == 0) m_busy <= 1'b0;
                else m_cnt <= m_cnt - 1;
            end
        end
    end

    // Record every start pulse and whether the transmitter was still busy then.
    always @(negedge clk) begin
        if (tx_start) begin
            starts_q.push_back(tx_data);
            busy_q.push_back(tx_busy);
            $display("tx_start data=%02h busy=%0b count=%0d", tx_data, tx_busy, fifo_count);
        end
    end

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic f,
                                input logic b, input logic c, input logic er,
                                input logic es, input logic [7:0] et,
                                input logic [4:0] ec, input logic ee);
        vec_t r;
        r.v = v; r.d = d; r.f = f; r.b = b; r.c = c;
        r.e_rdy = er; r.e_st = es; r.e_txd = et; r.e_cnt = ec; r.e_err = ee;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired got timeout expected event", name);
    endtask

    // Called at a negedge; holds a byte until s_ready lets it through.
    task automatic push_byte(input logic [7:0] d);
        int n = 0;
        while (!s_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) bound_fail("push_ready");
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl);
        int n = 0;
        while (tx_busy !== lvl && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (tx_busy !== lvl) bound_fail("wait_busy");
    endtask

    task automatic check_order(input string name);
        chk({name, "_starts"}, 32'(starts_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < starts_q.size(); i++) begin
            chk($sformatf("%s_data%0d", name, i), 32'(starts_q[i]), 32'(exp_q[i]));
            chk($sformatf("%s_busy_at_start%0d", name, i), 32'(busy_q[i]), 32'd0);
        end
        $display("%s: %0d starts observed", name, starts_q.size());
    endtask

    initial begin
        //               v     d      f     b     c     rdy   st    txd    cnt   err
        tbl[0]  = mk(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 5'd1, 1'b0);
        tbl[1]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 5'd0, 1'b0);
        tbl[2]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 5'd0, 1'b0);
        tbl[3]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 5'd0, 1'b0);
        tbl[4]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 5'd0, 1'b0);
        tbl[5]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 5'd0, 1'b0);
        tbl[6]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 5'd0, 1'b1);
        tbl[7]  = mk(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 5'd1, 1'b1);
        tbl[8]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 5'd0, 1'b1);
        tbl[9]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 5'd0, 1'b0);
        tbl[10] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 5'd0, 1'b0);
        tbl[11] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 5'd0, 1'b0);
        tbl[12] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 5'd0, 1'b0);
        tbl[13] = mk(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 5'd0, 1'b0);
        tbl[14] = mk(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 5'd1, 1'b0);
        tbl[15] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 5'd0, 1'b0);
        tbl[16] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 5'd0, 1'b0);
        tbl[17] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 5'd0, 1'b0);
        tbl[18] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 5'd0, 1'b0);
        tbl[19] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 5'd0, 1'b0);
        tbl[20] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h11, 5'd0, 1'b1);
        tbl[21] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h11, 5'd0, 1'b0);
        tbl[22] = mk(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 5'd1, 1'b0);
        tbl[23] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 5'd0, 1'b0);
        tbl[24] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 5'd0, 1'b0);

        // Reset state while rst is held.
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(s_ready), 32'd0);
        chk("reset_start", 32'(tx_start), 32'd0);
        chk("reset_txd", 32'(tx_data), 32'h00);
        chk("reset_count", 32'(fifo_count), 32'd0);
        chk("reset_err", 32'(timeout_err), 32'd0);
        rst = 1'b0;

        // Cycle table: drive at negedge, let one edge pass, check at next negedge.
        for (int i = 0; i < 25; i++) begin
            s_valid   = tbl[i].v;
            s_data    = tbl[i].d;
            flush     = tbl[i].f;
            tbl_busy  = tbl[i].b;
            clear_err = tbl[i].c;
            @(posedge clk);
            @(negedge clk);
            $display("vec %0d: ready=%0b start=%0b data=%02h count=%0d err=%0b",
                     i, s_ready, tx_start, tx_data, fifo_count, timeout_err);
            chk($sformatf("vec%0d_ready", i), 32'(s_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d_start", i), 32'(tx_start), 32'(tbl[i].e_st));
            chk($sformatf("vec%0d_txd", i), 32'(tx_data), 32'(tbl[i].e_txd));
            chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(tbl[i].e_cnt));
            chk($sformatf("vec%0d_err", i), 32'(timeout_err), 32'(tbl[i].e_err));
        end
        s_valid = 1'b0; flush = 1'b0; clear_err = 1'b0; tbl_busy = 1'b0;
        model_en = 1'b1;

        // Single byte with a long busy period.
        busy_len = 160;
        starts_q.delete(); busy_q.delete(); exp_q.delete();
        push_byte(8'hA5);
        repeat (180) @(negedge clk);
        exp_q.push_back(8'hA5);
        check_order("single");
        chk("single_count", 32'(fifo_count), 32'd0);

        // Burst of eight while the transmitter is busy with a lead byte.
        busy_len = 20;
        starts_q.delete(); busy_q.delete(); exp_q.delete();
        push_byte(8'hEE);
        exp_q.push_back(8'hEE);
        wait_busy(1'b1);
        for (int i = 1; i <= 8; i++) begin
            push_byte(8'(i));
            exp_q.push_back(8'(i));
        end
        chk("burst_ready_full", 32'(s_ready), 32'd0);
        chk("burst_count_full", 32'(fifo_count), 32'd8);
        s_valid = 1'b1; s_data = 8'hFF;
        @(negedge clk);
        s_valid = 1'b0;
        chk("burst_push_while_full", 32'(fifo_count), 32'd8);
        repeat (300) @(negedge clk);
        check_order("burst");

        // Flush while five bytes wait behind an in-flight byte.
        busy_len = 20;
        starts_q.delete(); busy_q.delete(); exp_q.delete();
        push_byte(8'hF0);
        exp_q.push_back(8'hF0);
        wait_busy(1'b1);
        for (int i = 0; i < 5; i++) push_byte(8'h21 + 8'(i));
        chk("flush_count_before", 32'(fifo_count), 32'd5);
        flush = 1'b1;
        #1;
        chk("flush_ready", 32'(s_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_count_after", 32'(fifo_count), 32'd0);
        repeat (60) @(negedge clk);
        check_order("flush");

        // Push and pop on the same edge at count 3.
        busy_len = 12;
        starts_q.delete(); busy_q.delete(); exp_q.delete();
        push_byte(8'h40);
        wait_busy(1'b1);
        for (int i = 1; i <= 3; i++) push_byte(8'h40 + 8'(i));
        chk("simul_count_before", 32'(fifo_count), 32'd3);
        wait_busy(1'b0);
        @(negedge clk);
        s_valid = 1'b1; s_data = 8'h44;
        @(negedge clk);
        s_valid = 1'b0;
        chk("simul_count", 32'(fifo_count), 32'd3);
        chk("simul_start", 32'(tx_start), 32'd1);
        chk("simul_txd", 32'(tx_data), 32'h41);
        for (int i = 0; i <= 4; i++) exp_q.push_back(8'h40 + 8'(i));
        repeat (120) @(negedge clk);
        check_order("simul");

        // Twenty bytes through the 8-deep queue, pointers wrap.
        busy_len = 3;
        starts_q.delete(); busy_q.delete(); exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            push_byte(8'h80 + 8'(i));
            exp_q.push_back(8'h80 + 8'(i));
        end
        repeat (250) @(negedge clk);
        check_order("wrap");

        // Asynchronous reset in WAIT_DONE with four bytes queued.
        busy_len = 30;
        starts_q.delete(); busy_q.delete(); exp_q.delete();
        push_byte(8'hC0);
        exp_q.push_back(8'hC0);
        wait_busy(1'b1);
        repeat (2) @(negedge clk);
        for (int i = 1; i <= 4; i++) push_byte(8'hC0 + 8'(i));
        chk("rstmid_count_before", 32'(fifo_count), 32'd4);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_count", 32'(fifo_count), 32'd0);
        chk("rstmid_start", 32'(tx_start), 32'd0);
        chk("rstmid_txd", 32'(tx_data), 32'h00);
        chk("rstmid_err", 32'(timeout_err), 32'd0);
        chk("rstmid_ready", 32'(s_ready), 32'd0);
        repeat (2) @(negedge clk);
        chk("rstmid_ready_held", 32'(s_ready), 32'd0);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        check_order("rstmid");
        chk("rstmid_count_after", 32'(fifo_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 Parameter DEPTH, default 8, FIFO depth in bytes; power of two, 2..16.
REQ-002 Parameter TIMEOUT, default 4, maximum clk cycles to wait for tx_busy after the tx_start pulse.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 s_valid  input  1  upstream byte valid.
REQ-006 s_data  input  8  upstream byte.
REQ-007 s_ready  output  1  FIFO can accept a byte this cycle.
REQ-008 flush  input  1  discard all queued bytes.
REQ-009 tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-010 tx_data  output  8  byte presented to the UART transmitter.
REQ-011 tx_busy  input  1  transmitter busy flag; rises 2 cycles after tx_start is accepted.
REQ-012 fifo_count  output  5  number of queued bytes, 0..DEPTH.
REQ-013 timeout_err  output  1  sticky flag: tx_busy never rose.
REQ-014 clear_err  input  1  synchronous clear of timeout_err.

Function
REQ-015 A push SHALL occur on any cycle where s_valid && s_ready; s_ready = (fifo_count < DEPTH) && !flush, from registered state only.
REQ-016 A push while full SHALL be impossible; a push and a pop in the same cycle SHALL leave fifo_count unchanged.
REQ-017 Read/write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; fifo_count SHALL be a separate counter.
REQ-018 FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-019 IDLE: if fifo_count != 0 and !flush, pop the head byte into the tx_data register and go to START; otherwise stay.
REQ-020 START: tx_start = 1 for exactly this one cycle; go to WAIT_BUSY and load the timeout counter with TIMEOUT.
REQ-021 WAIT_BUSY: if tx_busy = 1, go to WAIT_DONE; else decrement the counter; when the counter reaches 0, set timeout_err and go to IDLE.
REQ-022 WAIT_DONE: on tx_busy = 0, go to IDLE.
REQ-023 tx_start SHALL be a registered Moore output of START, 0 in every other state.
REQ-024 tx_data SHALL remain stable from START until the next pop.
REQ-025 Latency: a byte pushed into an empty FIFO with the FSM in IDLE at edge N SHALL produce tx_start = 1 in the cycle after edge N+1.
REQ-026 flush SHALL zero the pointers and fifo_count next edge, and SHALL suppress any pop that same cycle.
REQ-027 flush SHALL NOT abort a byte already in START/WAIT_BUSY/WAIT_DONE.
REQ-028 clear_err SHALL clear timeout_err; if a set and a clear occur in the same cycle, set wins.
REQ-029 tx_busy = 1 observed in IDLE SHALL be ignored: no pop and no error.

Reset
REQ-030 Asserting rst SHALL immediately force:
- state IDLE;
- pointers and fifo_count 0;
- tx_start 0, tx_data 8'h00, timeout_err 0.
REQ-031 While rst is asserted, s_ready SHALL be 0.
REQ-032 Reset asserted mid-transfer SHALL discard the queue and the in-flight byte, with no tx_start after release until a new push.

Structure
REQ-033 Package uart_feeder_pkg SHALL hold the FSM state enum (2-bit) and default constants FEEDER_DEPTH = 8 and FEEDER_TIMEOUT = 4.
REQ-034 The FIFO storage, pointers and count SHALL be a sub-module sync_fifo (parameter DEPTH, width 8); the FSM and error logic stay in uart_tx_feeder.

Verification
REQ-035 Single byte: push 8'hA5 with a transmitter model raising tx_busy 2 cycles after tx_start for 160 cycles -> exactly one tx_start, tx_data = 8'hA5, count returns to 0.
REQ-036 Burst: push 8'h01..8'h08 back-to-back -> s_ready = 0 after the 8th push (count = 8 before the first pop), 8 tx_start pulses in order 01..08, each separated by full tx_busy high periods.
REQ-037 Timeout: tx_busy tied 0, push 8'h3C -> timeout_err = 1 exactly TIMEOUT = 4 cycles after WAIT_BUSY entry, FSM in IDLE; next byte still sent; clear_err -> 0.
REQ-038 Flush: push 5 bytes while the transmitter is busy with the first, assert flush -> count = 0, the in-flight byte completes, no further tx_start.
REQ-039 Simultaneous push and pop at count 3 -> count stays 3; wrap test of 20 bytes through DEPTH 8 -> order preserved.
REQ-040 Reset mid-transfer in WAIT_DONE with count 4 -> all outputs at reset values immediately; no tx_start after release.
